// File: rtl/mips_regfile_pkg.sv
// Shared register-file types for the write-back queue.
// Register index width, register-0 constant and the pending-entry struct.
package mips_regfile_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

   typedef struct packed {
      reg_idx_t          rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// Youngest-match search over the pending write-back entries.
// One instance per register-file read port.
module wbq_bypass_match
   import mips_regfile_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  wb_entry_t [DEPTH-1:0] entries_i,
   input  logic [PW-1:0]         rd_ptr_i,
   input  logic [CW-1:0]         count_i,
   input  reg_idx_t              raddr_i,
   output logic                  hit_o,
   output logic [N-1:0]          data_o
);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last hit is the youngest match.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_i + PW'(i);
         if ((CW'(i) < count_i) &&
             (raddr_i != REG_ZERO) &&
             (entries_i[idx].rd == raddr_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding the register-file write port.
// Define WRITEBACK_QUEUE_BYPASS_EN to enable read-port bypass lookup.
module writeback_queue
   import mips_regfile_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_valid,
   output logic                         wb_ready,
   input  logic [4:0]                   wb_reg,
   input  logic [N-1:0]                 wb_data,
   input  logic                         hold,
   output logic                         RegWrite,
   output logic [4:0]                   WriteRegister,
   output logic [N-1:0]                 WriteData,
   input  logic [4:0]                   ReadRegister1,
   input  logic [4:0]                   ReadRegister2,
   output logic                         Bypass1_valid,
   output logic [N-1:0]                 Bypass1_data,
   output logic                         Bypass2_valid,
   output logic [N-1:0]                 Bypass2_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q,  count_d;
   logic                  push, pop, nonempty;

   assign nonempty = (count_q != '0);
   assign wb_ready = (count_q < CW'(DEPTH));
   assign RegWrite = nonempty & ~hold;
   assign pop      = RegWrite;
   assign push     = wb_valid & wb_ready & (wb_reg != REG_ZERO);
   assign count    = count_q;

   assign WriteRegister = nonempty ? mem_q[rd_ptr_q].rd   : '0;
   assign WriteData     = nonempty ? mem_q[rd_ptr_q].data : '0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; count_q alone defines which slots are live.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= '{rd: wb_reg, data: wb_data};
      end
   end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
   wbq_bypass_match #(
      .N     (N),
      .DEPTH (DEPTH),
      .PW    (PW),
      .CW    (CW)
   ) u_match1 (
      .entries_i (mem_q),
      .rd_ptr_i  (rd_ptr_q),
      .count_i   (count_q),
      .raddr_i   (ReadRegister1),
      .hit_o     (Bypass1_valid),
      .data_o    (Bypass1_data)
   );

   wbq_bypass_match #(
      .N     (N),
      .DEPTH (DEPTH),
      .PW    (PW),
      .CW    (CW)
   ) u_match2 (
      .entries_i (mem_q),
      .rd_ptr_i  (rd_ptr_q),
      .count_i   (count_q),
      .raddr_i   (ReadRegister2),
      .hit_o     (Bypass2_valid),
      .data_o    (Bypass2_data)
   );
`else
   logic unused_rr;
   assign unused_rr     = ^{ReadRegister1, ReadRegister2};
   assign Bypass1_valid = 1'b0;
   assign Bypass1_data  = '0;
   assign Bypass2_valid = 1'b0;
   assign Bypass2_data  = '0;
`endif

endmodule
